// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: fetch FSM states, datapath width, PC step and NOP encoding.
package arm_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] PC_INC  = 32'd4;
   localparam logic [INSTR_W-1:0] ARM_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2
   } fetch_state_t;

   // Instruction fetches are always word aligned; low address bits are discarded.
   function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
      return addr & ~(PC_INC - 32'd1);
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
   import arm_pkg::*;

   logic               imem_req;
   logic [INSTR_W-1:0] imem_addr;
   logic               imem_ready;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rvalid, imem_rdata
   );

endinterface

// File: rtl/if_perf_counters.sv
// Saturating fetch-unit event counters: consumed instructions and dropped memory responses.
module if_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_inc,
   input  logic        discard_inc,
   output logic [31:0] fetch_count,
   output logic [15:0] discard_count
);

   logic [31:0] fetch_count_reg;
   logic [15:0] discard_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_reg   <= '0;
         discard_count_reg <= '0;
      end else begin
         if (fetch_inc && (fetch_count_reg != '1))
            fetch_count_reg <= fetch_count_reg + 32'd1;
         if (discard_inc && (discard_count_reg != '1))
            discard_count_reg <= discard_count_reg + 16'd1;
      end
   end

   assign fetch_count   = fetch_count_reg;
   assign discard_count = discard_count_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues one outstanding imem request, presents each fetch until consumed.
// Optional IF_PERF_CNT_EN adds fetch_count/discard_count outputs.
module if_fetch_unit
   import arm_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = ARM_NOP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [INSTR_W-1:0] branch_addr,
   if_fetch_unit_if.master    imem,
   output logic               fetch_valid,
   output logic [INSTR_W-1:0] PC_out,
   output logic [INSTR_W-1:0] Instruction_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [15:0]        discard_count
`endif
);

   fetch_state_t       state_reg, state_next;
   logic [INSTR_W-1:0] pc_reg, pc_next;
   logic               discard_reg, discard_next;
   logic               fetch_valid_reg, fetch_valid_next;
   logic [INSTR_W-1:0] pc_out_reg, pc_out_next;
   logic [INSTR_W-1:0] instr_reg, instr_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= FS_REQ;
         pc_reg          <= RESET_PC;
         discard_reg     <= 1'b0;
         fetch_valid_reg <= 1'b0;
         pc_out_reg      <= '0;
         instr_reg       <= NOP_INSTR;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         discard_reg     <= discard_next;
         fetch_valid_reg <= fetch_valid_next;
         pc_out_reg      <= pc_out_next;
         instr_reg       <= instr_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      discard_next     = discard_reg;
      fetch_valid_next = fetch_valid_reg;
      pc_out_next      = pc_out_reg;
      instr_next       = instr_reg;

      if (branch_taken) begin
         // Redirect wins; an already-accepted request must still be drained, so it is marked stale.
         pc_next          = word_align(branch_addr);
         fetch_valid_next = 1'b0;
         pc_out_next      = '0;
         instr_next       = NOP_INSTR;
         unique case (state_reg)
            FS_REQ: begin
               if (imem.imem_ready) begin
                  discard_next = 1'b1;
                  state_next   = FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (imem.imem_rvalid) begin
                  discard_next = 1'b0;
                  state_next   = FS_REQ;
               end else begin
                  discard_next = 1'b1;
               end
            end
            default: state_next = FS_REQ;
         endcase
      end else begin
         unique case (state_reg)
            FS_REQ: begin
               if (imem.imem_ready)
                  state_next = FS_WAIT;
            end
            FS_WAIT: begin
               if (imem.imem_rvalid) begin
                  if (discard_reg) begin
                     discard_next = 1'b0;
                     state_next   = FS_REQ;
                  end else begin
                     fetch_valid_next = 1'b1;
                     pc_out_next      = pc_reg + PC_INC;
                     instr_next       = imem.imem_rdata;
                     state_next       = FS_HOLD;
                  end
               end
            end
            default: begin
               if (!freeze) begin
                  pc_next          = pc_reg + PC_INC;
                  fetch_valid_next = 1'b0;
                  pc_out_next      = '0;
                  instr_next       = NOP_INSTR;
                  state_next       = FS_REQ;
               end
            end
         endcase
      end
   end

   assign imem.imem_req   = (state_reg == FS_REQ);
   assign imem.imem_addr  = pc_reg;
   assign fetch_valid     = fetch_valid_reg;
   assign PC_out          = pc_out_reg;
   assign Instruction_out = instr_reg;

`ifdef IF_PERF_CNT_EN
   logic consumed;
   logic dropped;

   assign consumed = (state_reg == FS_HOLD) && !freeze && !branch_taken;
   assign dropped  = (state_reg == FS_WAIT) && imem.imem_rvalid && (discard_reg || branch_taken);

   if_perf_counters u_perf (
      .clk           (clk),
      .rst           (rst),
      .fetch_inc     (consumed),
      .discard_inc   (dropped),
      .fetch_count   (fetch_count),
      .discard_count (discard_count)
   );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, corner sequences, randomized run vs model.
module tb_if_fetch_unit;
   import arm_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        fetch_valid;
   logic [31:0] PC_out;
   logic [31:0] Instruction_out;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [15:0] discard_count;
`endif

   if_fetch_unit_if imem ();

   if_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .imem            (imem),
      .fetch_valid     (fetch_valid),
      .PC_out          (PC_out),
      .Instruction_out (Instruction_out)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_count     (fetch_count),
      .discard_count   (discard_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        frz;
      logic        br;
      logic [31:0] ba;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_fv;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vt[19];

   function automatic vec_t mk(input logic e_req, input logic [31:0] e_addr, input logic e_fv,
                               input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic frz, input logic br, input logic [31:0] ba);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rd = rd; v.frz = frz; v.br = br; v.ba = ba;
      v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc = e_pc; v.e_instr = e_instr;
      return v;
   endfunction

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_fv, input logic [31:0] e_pc, input logic [31:0] e_instr);
      chk({tag, " imem_req"}, {31'd0, imem.imem_req}, {31'd0, e_req});
      if (e_req)
         chk({tag, " imem_addr"}, imem.imem_addr, e_addr);
      chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
      chk({tag, " PC_out"}, PC_out, e_pc);
      chk({tag, " Instruction_out"}, Instruction_out, e_instr);
      $display("%s: req=%b addr=%h fv=%b pc=%h instr=%h", tag, imem.imem_req, imem.imem_addr,
               fetch_valid, PC_out, Instruction_out);
   endtask

   // Drive one cycle of inputs and advance to the next falling edge.
   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic frz, input logic br, input logic [31:0] ba);
      imem.imem_ready  = rdy;
      imem.imem_rvalid = rv;
      imem.imem_rdata  = rd;
      freeze           = frz;
      branch_taken     = br;
      branch_addr      = ba;
      @(negedge clk);
   endtask

   // Reference model state (transaction level)
   logic [31:0] next_addr, out_addr, pres_pc, pres_instr;
   logic        mdl_out, stale, presenting;
   logic        mem_busy;
   int          mem_lat;
   logic [31:0] mem_addr;

   initial begin
      logic [31:0] d0, d1, d2, d3, d4, d5, d6;
      d0 = 32'hE3A0_0001; d1 = 32'hE280_0001; d2 = 32'hE1A0_F00E;
      d3 = 32'hE3A0_1005; d4 = 32'hE081_1002; d5 = 32'hE590_2000; d6 = 32'hEAFF_FFFE;

      //           e_req e_addr        fv  e_pc          e_instr  rdy rv rdata fz br baddr
      vt[0]  = mk(1'b1, 32'h0,   1'b0, 32'h0,  NOP, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[1]  = mk(1'b0, 32'h0,   1'b0, 32'h0,  NOP, 1'b0, 1'b1, d0,    1'b0, 1'b0, 32'h0);
      vt[2]  = mk(1'b0, 32'h0,   1'b1, 32'h4,  d0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[3]  = mk(1'b1, 32'h4,   1'b0, 32'h0,  NOP, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[4]  = mk(1'b0, 32'h0,   1'b0, 32'h0,  NOP, 1'b0, 1'b1, d1,    1'b0, 1'b0, 32'h0);
      vt[5]  = mk(1'b0, 32'h0,   1'b1, 32'h8,  d1,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[6]  = mk(1'b1, 32'h8,   1'b0, 32'h0,  NOP, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[7]  = mk(1'b0, 32'h0,   1'b0, 32'h0,  NOP, 1'b0, 1'b1, d2,    1'b0, 1'b0, 32'h0);
      vt[8]  = mk(1'b0, 32'h0,   1'b1, 32'hC,  d2,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[9]  = mk(1'b1, 32'hC,   1'b0, 32'h0,  NOP, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[10] = mk(1'b0, 32'h0,   1'b0, 32'h0,  NOP, 1'b0, 1'b1, d3,    1'b0, 1'b0, 32'h0);
      vt[11] = mk(1'b0, 32'h0,   1'b1, 32'h10, d3,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      vt[12] = mk(1'b0, 32'h0,   1'b1, 32'h10, d3,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      vt[13] = mk(1'b0, 32'h0,   1'b1, 32'h10, d3,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      vt[14] = mk(1'b0, 32'h0,   1'b1, 32'h10, d3,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[15] = mk(1'b1, 32'h10,  1'b0, 32'h0,  NOP, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vt[16] = mk(1'b0, 32'h0,   1'b0, 32'h0,  NOP, 1'b0, 1'b1, d4,    1'b0, 1'b0, 32'h0);
      vt[17] = mk(1'b0, 32'h0,   1'b1, 32'h14, d4,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
      vt[18] = mk(1'b1, 32'h200, 1'b0, 32'h0,  NOP, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      rst = 1'b1;
      imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
      freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk_out("reset", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
`ifdef IF_PERF_CNT_EN
      chk("reset fetch_count", fetch_count, 32'd0);
      chk("reset discard_count", {16'd0, discard_count}, 32'd0);
`endif
      rst = 1'b0;

      // Sequential fetch, freeze in HOLD, branch+freeze in HOLD
      for (int i = 0; i < 19; i++) begin
         chk_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_fv, vt[i].e_pc, vt[i].e_instr);
         drive(vt[i].rdy, vt[i].rv, vt[i].rd, vt[i].frz, vt[i].br, vt[i].ba);
      end

      // Branch while waiting; the stale response two cycles later must be dropped
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_out("br_wait accept", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
      chk_out("br_wait redirect", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_out("br_wait idle", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
      chk_out("br_wait dropped", 1'b1, 32'h100, 1'b0, 32'h0, NOP);
`ifdef IF_PERF_CNT_EN
      chk("br_wait discard_count", {16'd0, discard_count}, 32'd1);
`endif
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, d5, 1'b0, 1'b0, 32'h0);
      chk_out("br_wait target", 1'b0, 32'h0, 1'b1, 32'h104, d5);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_out("br_wait next", 1'b1, 32'h104, 1'b0, 32'h0, NOP);
`ifdef IF_PERF_CNT_EN
      chk("br_wait fetch_count", fetch_count, 32'd5);
`endif

      // Ready held low: request held stable
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         chk_out($sformatf("stall%0d", i), 1'b1, 32'h104, 1'b0, 32'h0, NOP);
      end

      // Asynchronous reset in WAIT, with a stale rvalid around it
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_out("pre_rst wait", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      imem.imem_ready = 1'b0;
      #2 rst = 1'b1;
      #1 chk_out("async_rst", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
`ifdef IF_PERF_CNT_EN
      chk("async_rst fetch_count", fetch_count, 32'd0);
`endif
      imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      chk_out("post_rst rvalid", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

      // PC wrap at the top of the address space
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      chk_out("wrap redirect", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, d6, 1'b0, 1'b0, 32'h0);
      chk_out("wrap fetch", 1'b0, 32'h0, 1'b1, 32'h0, d6);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_out("wrap next", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
`ifdef IF_PERF_CNT_EN
      chk("wrap fetch_count", fetch_count, 32'd1);
      chk("wrap discard_count", {16'd0, discard_count}, 32'd0);
`endif

      // Randomized run against the transaction-level model
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      next_addr = 32'h0; out_addr = 32'h0; pres_pc = 32'h0; pres_instr = NOP;
      mdl_out = 1'b0; stale = 1'b0; presenting = 1'b0;
      mem_busy = 1'b0; mem_lat = 0; mem_addr = 32'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        rdy, rv, frz, br, resp, acc, mem_resp;
         logic [31:0] rd, ba;
         acc = 1'b0;
         chk_out($sformatf("rnd%0d", cyc), !mdl_out && !presenting, next_addr, presenting,
                 presenting ? pres_pc : 32'h0, presenting ? pres_instr : NOP);
         rdy = ($urandom % 10) < 6;
         frz = ($urandom % 10) < 4;
         br  = ($urandom % 20) == 0;
         ba  = $urandom;
         mem_resp = mem_busy && (mem_lat == 0);
         if (mem_resp) begin
            rv = 1'b1;
            rd = mem_data(mem_addr);
         end else begin
            rv = !mem_busy && (($urandom % 10) == 0);
            rd = $urandom;
         end
         // Memory side follows what the DUT actually requests
         if (mem_busy) begin
            if (mem_lat == 0) mem_busy = 1'b0;
            else mem_lat--;
         end else if (imem.imem_req && rdy) begin
            mem_busy = 1'b1;
            mem_addr = imem.imem_addr;
            mem_lat  = int'($urandom % 3);
         end
         // Model: one request in flight, stale if a redirect occurs before its data returns
         acc  = !mdl_out && !presenting && rdy;
         resp = mdl_out && mem_resp;
         if (br) begin
            next_addr  = ba & 32'hFFFF_FFFC;
            presenting = 1'b0;
            if (resp) mdl_out = 1'b0;
            else if (mdl_out) stale = 1'b1;
            if (acc) begin
               mdl_out = 1'b1;
               stale   = 1'b1;
            end
         end else if (acc) begin
            mdl_out  = 1'b1;
            stale    = 1'b0;
            out_addr = next_addr;
         end else if (resp) begin
            mdl_out = 1'b0;
            if (!stale) begin
               presenting = 1'b1;
               pres_pc    = out_addr + 32'd4;
               pres_instr = mem_data(out_addr);
            end
            stale = 1'b0;
         end else if (presenting && !frz) begin
            presenting = 1'b0;
            next_addr  = next_addr + 32'd4;
         end
         drive(rdy, rv, rd, frz, br, ba);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
